mem_port_arbiter: RTL



---
 rtl/mem_port_arbiter.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single external memory port between instruction fetch and load/store.
// One transaction at a time: IDLE picks an owner, BUSY holds the request, RESP pulses the ack.
module mem_port_arbiter #(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int MAX_WAIT     = 15,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                    clock_in,
  input  logic                    reset_in,
  input  logic                    if_req_in,
  input  logic [ADDR_WIDTH-1:0]   if_addr_in,
  input  logic                    if_flush_in,
  output logic                    if_ack_out,
  output logic                    if_err_out,
  output logic [DATA_WIDTH-1:0]   if_rdata_out,
  input  logic                    lsu_req_in,
  input  logic                    lsu_we_in,
  input  logic [ADDR_WIDTH-1:0]   lsu_addr_in,
  input  logic [DATA_WIDTH-1:0]   lsu_wdata_in,
  input  logic [DATA_WIDTH/8-1:0] lsu_wstrb_in,
  output logic                    lsu_ack_out,
  output logic                    lsu_err_out,
  output logic [DATA_WIDTH-1:0]   lsu_rdata_out,
  output logic                    mem_req_out,
  output logic                    mem_we_out,
  output logic [ADDR_WIDTH-1:0]   mem_addr_out,
  output logic [DATA_WIDTH-1:0]   mem_wdata_out,
  output logic [DATA_WIDTH/8-1:0] mem_wstrb_out,
  input  logic [DATA_WIDTH-1:0]   mem_rdata_in,
  input  logic                    mem_ack_in,
  output logic [1:0]              grant_out
);

  // Handshake: requesters hold req (and its payload) until they see their one-cycle ack;
  // the memory request stays high until mem_ack_in or the wait-state timeout.

  localparam int STRB_WIDTH = DATA_WIDTH / 8;
  localparam logic [7:0] WAIT_LAST  = 8'(MAX_WAIT - 1);
  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
  typedef enum logic [1:0] {OWN_NONE = 2'b00, OWN_IF = 2'b01, OWN_LSU = 2'b10} owner_t;

  state_t                 state_q, state_d;
  owner_t                 owner_q, owner_d;
  logic [7:0]             wait_q, wait_d;
  logic [3:0]             starve_q, starve_d;
  logic                   discard_q, discard_d;
  logic                   err_q, err_d;
  logic [DATA_WIDTH-1:0]  rdata_q, rdata_d;
  logic                   we_q, we_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic [DATA_WIDTH-1:0]  wdata_q, wdata_d;
  logic [STRB_WIDTH-1:0]  wstrb_q, wstrb_d;
  logic                   if_starved;
  logic                   resp_if, resp_lsu;

  assign if_starved = if_req_in && (starve_q == STARVE_MAX);

  always_ff @(posedge clock_in) begin
    if (reset_in) begin
      state_q   <= IDLE;
      owner_q   <= OWN_NONE;
      wait_q    <= '0;
      starve_q  <= '0;
      discard_q <= 1'b0;
      err_q     <= 1'b0;
      rdata_q   <= '0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      wait_q    <= wait_d;
      starve_q  <= starve_d;
      discard_q <= discard_d;
      err_q     <= err_d;
      rdata_q   <= rdata_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    wait_d    = wait_q;
    starve_d  = starve_q;
    discard_d = discard_q;
    err_d     = err_q;
    rdata_d   = rdata_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    case (state_q)
      IDLE: begin
        wait_d    = '0;
        discard_d = 1'b0;
        if (lsu_req_in && !if_starved) begin
          owner_d = OWN_LSU;
          we_d    = lsu_we_in;
          addr_d  = lsu_addr_in;
          wdata_d = lsu_wdata_in;
          wstrb_d = lsu_we_in ? lsu_wstrb_in : '0;
          state_d = BUSY;
          // LSU only wins over a pending fetch while starve_q < STARVE_MAX, so no overflow.
          if (if_req_in) starve_d = starve_q + 4'd1;
        end else if (if_req_in) begin
          owner_d  = OWN_IF;
          we_d     = 1'b0;
          addr_d   = if_addr_in;
          wdata_d  = '0;
          wstrb_d  = '0;
          starve_d = '0;
          state_d  = BUSY;
        end
      end
      BUSY: begin
        wait_d = wait_q + 8'd1;
        if (owner_q == OWN_IF && if_flush_in) discard_d = 1'b1;
        if (mem_ack_in) begin
          rdata_d = we_q ? '0 : mem_rdata_in;
          err_d   = 1'b0;
          state_d = RESP;
        end else if (wait_q == WAIT_LAST) begin
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        wait_d  = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // A flush arriving in the RESP cycle itself must still swallow the fetch ack.
  assign resp_if  = (state_q == RESP) && (owner_q == OWN_IF) && !discard_q && !if_flush_in;
  assign resp_lsu = (state_q == RESP) && (owner_q == OWN_LSU);

  assign if_ack_out    = resp_if;
  assign if_err_out    = resp_if && err_q;
  assign if_rdata_out  = resp_if ? rdata_q : '0;
  assign lsu_ack_out   = resp_lsu;
  assign lsu_err_out   = resp_lsu && err_q;
  assign lsu_rdata_out = resp_lsu ? rdata_q : '0;

  assign mem_req_out   = (state_q == BUSY);
  assign mem_we_out    = we_q;
  assign mem_addr_out  = addr_q;
  assign mem_wdata_out = wdata_q;
  assign mem_wstrb_out = wstrb_q;
  assign grant_out     = (state_q == BUSY) ? owner_q : OWN_NONE;

endmodule
